// File: rtl/mul_by_add_pkg.sv
// rtl/mul_by_add_pkg.sv - shared state encoding and data width for the multiply-by-add controller
package mul_by_add_pkg;

    localparam int DW = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mul_by_add_ctrl_if.sv
// rtl/mul_by_add_ctrl_if.sv - host/datapath handshake bundle for the multiply-by-add controller
interface mul_by_add_ctrl_if;

    logic start;
    logic abort;
    logic eqz;
    logic sel_b;
    logic ldA;
    logic ldB;
    logic clrP;
    logic ldP;
    logic decB;
    logic busy;
    logic done;
    logic timeout;

    modport master (
        output start, abort, eqz,
        input  sel_b, ldA, ldB, clrP, ldP, decB, busy, done, timeout
    );

    modport slave (
        input  start, abort, eqz,
        output sel_b, ldA, ldB, clrP, ldP, decB, busy, done, timeout
    );

endinterface

// File: rtl/mul_by_add_wdog.sv
// rtl/mul_by_add_wdog.sv - add-cycle watchdog counter with terminal-count compare
module mul_by_add_wdog #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(MAX_ITER));

endmodule

// File: rtl/mul_by_add_ctrl.sv
// rtl/mul_by_add_ctrl.sv - sequencer for 16-bit multiply by repeated addition
// Optional iteration watchdog enabled by defining MUL_BY_ADD_WDOG_EN.
module mul_by_add_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    mul_by_add_ctrl_if.slave bus
);

    import mul_by_add_pkg::*;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   sel_b_q, sel_b_d;
    logic   timeout_q, timeout_d;
    logic   ld_a, ld_b, clr_p, ld_p, dec_b;
    logic   wd_clr, wd_inc, expire;

`ifdef MUL_BY_ADD_WDOG_EN
    mul_by_add_wdog #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expire (expire)
    );
`else
    logic unused_wdog;
    assign expire      = 1'b0;
    assign unused_wdog = wd_clr ^ wd_inc ^ (CNT_W != MAX_ITER);
`endif

    // Strobes are Mealy so abort and eqz act within the same cycle.
    always_comb begin
        state_d   = state_q;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        clr_p     = 1'b0;
        ld_p      = 1'b0;
        dec_b     = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD_A;
            end
            LOAD_A: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    ld_a    = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    ld_b    = 1'b1;
                    clr_p   = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.eqz) begin
                    state_d = DONE;
                end else if (expire) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    ld_p   = 1'b1;
                    dec_b  = 1'b1;
                    wd_inc = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        sel_b_d = (state_d == LOAD_B);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_b_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_b_q   <= sel_b_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sel_b   = sel_b_q;
    assign bus.ldA     = ld_a;
    assign bus.ldB     = ld_b;
    assign bus.clrP    = clr_p;
    assign bus.ldP     = ld_p;
    assign bus.decB    = dec_b;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;

endmodule
